// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin system bus arbiter with transaction watchdog
module bus_arbiter #(
   parameter int N_MASTERS = 4,
   parameter int IDX_W     = 2,
   parameter int TIMEOUT   = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_MASTERS-1:0] req,
   output logic [N_MASTERS-1:0] grant,
   input  logic                 rd_bus,
   input  logic                 wr_bus,
   inout  wire                  fc_bus,
   output logic                 bus_err,
   output logic [IDX_W-1:0]     err_master
);

   typedef enum logic [1:0] {S_IDLE, S_GRANTED, S_FORCE} state_t;

   localparam logic [N_MASTERS-1:0] ONE_HOT0 = {{(N_MASTERS-1){1'b0}}, 1'b1};
   localparam logic [15:0]          WDOG_MAX = 16'(TIMEOUT - 1);

   state_t                 r_state, w_state_nx;
   logic [N_MASTERS-1:0]   r_grant, w_grant_nx;
   logic [IDX_W-1:0]       r_cur, w_cur_nx;
   logic [IDX_W-1:0]       r_last, w_last_nx;
   logic [IDX_W-1:0]       r_err_master, w_err_master_nx;
   logic [15:0]            r_wdog, w_wdog_nx;

   logic                   w_found;
   logic [IDX_W-1:0]       w_pick;
   logic [N_MASTERS-1:0]   w_req_sh;
   logic [N_MASTERS-1:0]   w_cur_sh;
   logic                   w_req_cur;
   logic                   w_txn;
   logic                   w_fc_done;

   // Only a clean 1 counts as completion; z/x from an idle bus does not.
   assign fc_bus     = (r_state == S_FORCE) ? 1'b1 : 1'bz;
   assign w_fc_done  = (fc_bus == 1'b1);
   assign w_txn      = rd_bus ^ wr_bus;
   assign w_cur_sh   = req >> r_cur;
   assign w_req_cur  = w_cur_sh[0];

   assign grant      = r_grant;
   assign bus_err    = (r_state == S_FORCE);
   assign err_master = r_err_master;

   // Round-robin search starting one past the previous owner.
   always_comb begin
      w_found  = 1'b0;
      w_pick   = '0;
      w_req_sh = '0;
      for (int i = 1; i <= N_MASTERS; i++) begin
         w_req_sh = req >> ((int'(r_last) + i) % N_MASTERS);
         if (!w_found && w_req_sh[0]) begin
            w_found = 1'b1;
            w_pick  = IDX_W'((int'(r_last) + i) % N_MASTERS);
         end
      end
   end

   always_comb begin
      w_state_nx      = r_state;
      w_grant_nx      = r_grant;
      w_cur_nx        = r_cur;
      w_last_nx       = r_last;
      w_wdog_nx       = r_wdog;
      w_err_master_nx = r_err_master;
      case (r_state)
         S_IDLE: begin
            w_grant_nx = '0;
            w_wdog_nx  = '0;
            if (w_found) begin
               w_state_nx = S_GRANTED;
               w_cur_nx   = w_pick;
               w_grant_nx = ONE_HOT0 << w_pick;
            end
         end
         S_GRANTED: begin
            if (!w_req_cur) begin
               w_state_nx = S_IDLE;
               w_grant_nx = '0;
               w_last_nx  = r_cur;
               w_wdog_nx  = '0;
            end else if (!w_txn || w_fc_done) begin
               w_wdog_nx = '0;
            end else if (r_wdog == WDOG_MAX) begin
               w_state_nx      = S_FORCE;
               w_err_master_nx = r_cur;
            end else begin
               w_wdog_nx = r_wdog + 16'd1;
            end
         end
         S_FORCE: begin
            w_wdog_nx = '0;
            if (!w_req_cur) begin
               w_state_nx = S_IDLE;
               w_grant_nx = '0;
               w_last_nx  = r_cur;
            end else begin
               w_state_nx = S_GRANTED;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_grant_nx = '0;
            w_wdog_nx  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_grant      <= '0;
         r_cur        <= '0;
         r_last       <= IDX_W'(N_MASTERS - 1);
         r_wdog       <= '0;
         r_err_master <= '0;
      end else begin
         r_state      <= w_state_nx;
         r_grant      <= w_grant_nx;
         r_cur        <= w_cur_nx;
         r_last       <= w_last_nx;
         r_wdog       <= w_wdog_nx;
         r_err_master <= w_err_master_nx;
      end
   end

endmodule
